// File: rtl/sram_port_arbiter_pkg.sv
// Shared ARM9 memory-map constants and arbiter types used by sram_port_arbiter.
// Optional loader-starvation stall is enabled with the ARB_STALL_EN macro.
package sram_port_arbiter_pkg;

  localparam int unsigned ARM9_AW           = 12;
  localparam int unsigned ARM9_SRAM_DEPTH   = 1 << ARM9_AW;
  localparam logic [3:0]  ARM9_SRAM_NIB     = 4'h4;
  localparam int unsigned ARM9_STARVE_LIMIT = 15;
  localparam logic [31:0] ARM9_UART_ADDR    = 32'he000_0000;
  localparam logic [31:0] ARM9_TIMER_ADDR   = 32'he000_0004;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_CPU,
    SRC_LD
  } sram_src_e;

  function automatic logic nib_match(input logic [31:0] addr, input logic [3:0] nib);
    return addr[31:28] == nib;
  endfunction

endpackage

// File: rtl/sram_starve_ctr.sv
// Loader starvation counter and registered core-enable; only built when ARB_STALL_EN is defined.
// Forces one core-stall cycle after STARVE_LIMIT ungranted loader cycles.
`ifdef ARB_STALL_EN
module sram_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic ld_req,
  input  logic ld_gnt,
  output logic cpu_en
);

  localparam int unsigned   CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          cpu_en_q;
  logic          cpu_en_next;
  logic          waiting;

  always_comb begin
    waiting     = ld_req & ~ld_gnt;
    cnt_next    = cnt;
    cpu_en_next = 1'b1;
    if (ld_gnt) begin
      cnt_next = '0;
    end else if (waiting && cnt != LIMIT) begin
      cnt_next = cnt + 1'b1;
    end
    // Stall also re-fires from a saturated count so a dropped-then-reissued request still gets through.
    if (waiting && cnt_next == LIMIT) begin
      cpu_en_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      cpu_en_q <= 1'b1;
    end else begin
      cnt      <= cnt_next;
      cpu_en_q <= cpu_en_next;
    end
  end

  assign cpu_en = cpu_en_q | ~rst;

endmodule
`endif

// File: rtl/sram_port_arbiter.sv
// Arbitrates the 4096x32 data SRAM between the ARM9 core (fixed priority) and the debug/DMA loader.
// Define ARB_STALL_EN to add the loader-starvation core stall (sram_starve_ctr).
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned AW           = ARM9_AW,
  parameter logic [3:0]  SRAM_NIB     = ARM9_SRAM_NIB,
  parameter int unsigned STARVE_LIMIT = ARM9_STARVE_LIMIT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_cen,
  input  logic          cpu_wen,
  input  logic [3:0]    cpu_flag,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_en,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [3:0]    ld_flag,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [31:0]   ld_rdata,
  output logic          sram_cs,
  output logic          sram_we,
  output logic [3:0]    sram_be,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  sram_src_e src;
  logic      cpu_hit;
  logic      cpu_rd_pend;
  logic      ld_rd_pend;
  logic      unused_bits;

`ifdef ARB_STALL_EN
  sram_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .ld_req (ld_req),
    .ld_gnt (ld_gnt),
    .cpu_en (cpu_en)
  );
`else
  localparam int unsigned unused_starve_limit = STARVE_LIMIT;
  assign cpu_en = 1'b1;
`endif

  assign cpu_hit = cpu_cen & nib_match(cpu_addr, SRAM_NIB) & cpu_en;

  always_comb begin
    src = SRC_NONE;
    if (rst) begin
      if (cpu_hit) begin
        src = SRC_CPU;
      end else if (ld_req) begin
        src = SRC_LD;
      end
    end
  end

  always_comb begin
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    unique case (src)
      SRC_CPU: begin
        sram_cs    = 1'b1;
        sram_we    = cpu_wen;
        sram_be    = cpu_flag;
        sram_addr  = cpu_addr[AW+1:2];
        sram_wdata = cpu_wdata;
      end
      SRC_LD: begin
        sram_cs    = 1'b1;
        sram_we    = ld_we;
        sram_be    = ld_flag;
        sram_addr  = ld_addr;
        sram_wdata = ld_wdata;
      end
      default: ;
    endcase
  end

  assign ld_gnt = (src == SRC_LD);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cpu_rd_pend <= 1'b0;
      ld_rd_pend  <= 1'b0;
    end else begin
      cpu_rd_pend <= (src == SRC_CPU) & ~cpu_wen;
      ld_rd_pend  <= (src == SRC_LD) & ~ld_we;
    end
  end

  // Gated by rst so a reset landing on the response cycle drops it.
  assign ld_rvalid = ld_rd_pend & rst;
  assign ld_rdata  = sram_rdata;
  assign cpu_rdata = sram_rdata;

  assign unused_bits = ^{cpu_addr[27:AW+2], cpu_addr[1:0], cpu_rd_pend};

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed table, corner sequences and a randomized run
// against a cycle-level reference of the arbitration rules; honours ARB_STALL_EN if defined.
module tb_sram_port_arbiter;

  localparam int unsigned LIMIT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_cen, cpu_wen;
  logic [3:0]  cpu_flag;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_en;
  logic        ld_req, ld_we;
  logic [3:0]  ld_flag;
  logic [11:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_gnt, ld_rvalid;
  logic [31:0] ld_rdata;
  logic        sram_cs, sram_we;
  logic [3:0]  sram_be;
  logic [11:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .AW(12),
    .SRAM_NIB(4'h4),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_cen(cpu_cen), .cpu_wen(cpu_wen), .cpu_flag(cpu_flag), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_en(cpu_en),
    .ld_req(ld_req), .ld_we(ld_we), .ld_flag(ld_flag), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_be(sram_be), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // SRAM macro: byte-enabled write, registered read.
  logic [31:0] mem [4096];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference state: expected memory contents and outstanding responses.
  logic [31:0] ref_mem [4096];
  bit          m_cpu_rd = 0, m_ld_rd = 0, m_stall = 0;
  logic [31:0] m_cpu_data, m_ld_data;
  int          m_wait = 0;
  bit          obs_gnt;

  task automatic model_step();
    bit hit, gnt, wr;
    int unsigned a;
    logic [31:0] wd;
    logic [3:0]  be;
    hit = rst && cpu_cen && ((cpu_addr >> 28) == 4) && !m_stall;
    gnt = rst && ld_req && !hit;
    a = 0; wr = 0; wd = '0; be = '0;
    if (hit) begin
      a = (cpu_addr / 4) % 4096; wr = cpu_wen; wd = cpu_wdata; be = cpu_flag;
    end else if (gnt) begin
      a = ld_addr; wr = ld_we; wd = ld_wdata; be = ld_flag;
    end
    obs_gnt = ld_gnt;
    chk("cpu_en", {31'b0, cpu_en}, (rst && m_stall) ? 32'd0 : 32'd1);
    chk("sram_cs", {31'b0, sram_cs}, {31'b0, hit || gnt});
    chk("ld_gnt", {31'b0, ld_gnt}, {31'b0, gnt});
    chk("ld_rvalid", {31'b0, ld_rvalid}, {31'b0, rst && m_ld_rd});
    if (rst && m_ld_rd) chk("ld_rdata", ld_rdata, m_ld_data);
    if (m_cpu_rd) chk("cpu_rdata", cpu_rdata, m_cpu_data);
    if (hit || gnt) begin
      chk("sram_addr", {20'b0, sram_addr}, a);
      chk("sram_we", {31'b0, sram_we}, {31'b0, wr});
      if (wr) begin
        chk("sram_be", {28'b0, sram_be}, {28'b0, be});
        chk("sram_wdata", sram_wdata, wd);
      end
    end
    m_cpu_rd = hit && !wr;
    m_ld_rd  = gnt && !wr;
    m_cpu_data = ref_mem[a];
    m_ld_data  = ref_mem[a];
    if ((hit || gnt) && wr)
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
`ifdef ARB_STALL_EN
    if (gnt) m_wait = 0;
    else if (ld_req) m_wait++;
    m_stall = ld_req && !gnt && (m_wait >= LIMIT);
    if (!rst) begin
      m_wait = 0;
      m_stall = 0;
    end
`endif
  endtask

  task automatic settle();
    @(negedge clk);
    model_step();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cpu(input logic cen, input logic wen, input logic [3:0] flag,
                           input logic [31:0] addr, input logic [31:0] wd);
    cpu_cen = cen; cpu_wen = wen; cpu_flag = flag; cpu_addr = addr; cpu_wdata = wd;
  endtask

  task automatic drive_ld(input logic req, input logic we, input logic [3:0] flag,
                          input logic [11:0] addr, input logic [31:0] wd);
    ld_req = req; ld_we = we; ld_flag = flag; ld_addr = addr; ld_wdata = wd;
  endtask

  typedef struct {
    logic        rst;
    logic        cen;
    logic        wen;
    logic [31:0] caddr;
    logic        lreq;
    logic        lwe;
    logic [11:0] laddr;
    logic        exp_cs;
    logic        exp_gnt;
    logic [11:0] exp_addr;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int gnt_idx;
    logic [31:0] cdat, ldat, old8;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h4000_0010, 1'b1, 1'b0, 12'h001, 1'b0, 1'b0, 12'h000};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h4000_0010, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h004};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 12'h007, 1'b1, 1'b1, 12'h007};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 1'b1, 1'b0, 12'h009, 1'b1, 1'b1, 12'h009};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h4000_FFFC, 1'b1, 1'b1, 12'h010, 1'b1, 1'b0, 12'hFFF};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h4000_0040, 1'b1, 1'b0, 12'h123, 1'b1, 1'b1, 12'h123};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h5000_0000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 32'h4000_4008, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h002};

    for (int i = 0; i < 4096; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    sram_rdata = '0;
    rst = 1'b0;
    drive_cpu(0, 0, 4'h0, '0, '0);
    drive_ld(0, 0, 4'h0, '0, '0);
    advance();

    // Directed table
    for (int i = 0; i < 9; i++) begin
      rst = vecs[i].rst;
      drive_cpu(vecs[i].cen, vecs[i].wen, 4'hF, vecs[i].caddr, $urandom);
      drive_ld(vecs[i].lreq, vecs[i].lwe, 4'hF, vecs[i].laddr, $urandom);
      settle();
      chk("tbl_cs", {31'b0, sram_cs}, {31'b0, vecs[i].exp_cs});
      chk("tbl_gnt", {31'b0, ld_gnt}, {31'b0, vecs[i].exp_gnt});
      if (vecs[i].exp_cs) chk("tbl_addr", {20'b0, sram_addr}, {20'b0, vecs[i].exp_addr});
      advance();
    end

    // Core read of word 4, then loader read of word 7; responses checked by the model
    drive_cpu(1, 0, 4'h0, 32'h4000_0010, '0);
    drive_ld(0, 0, 4'h0, '0, '0);
    settle(); advance();
    drive_cpu(0, 0, 4'h0, '0, '0);
    drive_ld(1, 0, 4'h0, 12'h007, '0);
    settle(); advance();
    drive_ld(0, 0, 4'h0, '0, '0);
    settle();
    chk("t2_rvalid", {31'b0, ld_rvalid}, 32'd1);
    advance();

    // Same-word collision: core writes low half first, loader overwrites next cycle
    cdat = 32'hCAFE_1234;
    ldat = 32'hA5A5_5A5A;
    old8 = ref_mem[8];
    drive_cpu(1, 1, 4'b0011, 32'h4000_0020, cdat);
    drive_ld(1, 1, 4'hF, 12'h008, ldat);
    settle();
    chk("collide_gnt", {31'b0, ld_gnt}, 32'd0);
    advance();
    chk("collide_core_word", mem[8], {old8[31:16], cdat[15:0]});
    drive_cpu(0, 0, 4'h0, '0, '0);
    settle(); advance();
    drive_ld(0, 0, 4'h0, '0, '0);
    chk("collide_final", mem[8], ldat);
    settle(); advance();

    // Reset in the cycle after a granted loader read drops the response
    drive_ld(1, 0, 4'h0, 12'h00A, '0);
    settle(); advance();
    drive_ld(0, 0, 4'h0, '0, '0);
    rst = 1'b0;
    settle();
    chk("rst_rvalid", {31'b0, ld_rvalid}, 32'd0);
    chk("rst_cpu_en", {31'b0, cpu_en}, 32'd1);
    advance();
    rst = 1'b1;
    settle(); advance();

    // Build up loader waits, then reset; the starvation count must restart from zero
    for (int i = 0; i < 8; i++) begin
      drive_cpu(1, 0, 4'h0, 32'h4000_0000 | (i << 2), '0);
      drive_ld(1, 0, 4'h0, 12'h055, '0);
      settle(); advance();
    end
    rst = 1'b0;
    settle(); advance();
    rst = 1'b1;

    // Continuous core SRAM traffic with loader request held
    gnt_idx = -1;
    for (int i = 0; i < 20; i++) begin
      drive_cpu(1, 0, 4'h0, 32'h4000_0100 + (i << 2), '0);
      drive_ld(gnt_idx < 0, 0, 4'h0, 12'h066, '0);
      settle();
      if (obs_gnt && gnt_idx < 0) gnt_idx = i;
      advance();
    end
`ifdef ARB_STALL_EN
    chk("starve_gnt_cycle", gnt_idx, LIMIT);
`else
    chk("starve_gnt_cycle", gnt_idx, -1);
`endif
    drive_cpu(0, 0, 4'h0, '0, '0);
    drive_ld(0, 0, 4'h0, '0, '0);
    settle(); advance();

    // Randomized traffic; loader holds its command until granted
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) != 0);
      drive_cpu($urandom_range(0, 9) < 7, $urandom_range(0, 1), 4'($urandom),
                ($urandom_range(0, 9) < 7) ? {4'h4, 28'($urandom)} : $urandom, $urandom);
      if (!ld_req || obs_gnt)
        drive_ld($urandom_range(0, 9) < 5, $urandom_range(0, 1), 4'($urandom), 12'($urandom), $urandom);
      settle(); advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
